uart_send: RTL and testbench
============================

# uart_send

UART transmitter for the FIR-filter coefficient link: accepts bytes over a valid/ready handshake, buffers them in a small FIFO, and serialises each as an 8N1 frame on `uart_t` toward the laptop. It is the transmit-side counterpart of the board's UART receiver. It is used to echo or acknowledge loaded coefficients and to stream filter status back to the host.

## Interface
- `CLK_FRE`, default 50000000: system clock frequency in Hz.
- `UART_BPS`, default 9600: line bit rate.
- `FIFO_DEPTH`, default 4: transmit FIFO entries. Must be a power of two, ≥2.
- `sys_clk` input 1: system clock, rising-edge.
- `sys_rst` input 1: reset, asynchronous, active-low.
- `tx_valid` input 1: byte on `tx_data` offered this cycle.
- `tx_data` input 8: byte to send.
- `tx_ready` output 1: FIFO can accept a byte. High when `fifo_count < FIFO_DEPTH`.
- `uart_t` output 1: serial line out, registered, idles high.
- `uart_busy` output 1: a frame is in progress, i.e. state ≠ IDLE.
- `fifo_count` output $clog2(FIFO_DEPTH)+1: number of bytes held in the FIFO, excluding the byte in the shifter.

## Operation
- `BPS_CNT = CLK_FRE/UART_BPS`, integer-truncated; 5208 at defaults. Bit counter is 16 bits wide; `BPS_CNT` must be ≤65535.
- Frame: start bit 0, then data bits 0..7 (LSB first), then one stop bit 1. Every bit is held exactly `BPS_CNT` cycles, so a frame is `10*BPS_CNT` cycles.
- Push: when `tx_valid && tx_ready` at a clock edge, write `tx_data` at the write pointer and increment it. Pointers wrap modulo `FIFO_DEPTH`.
- Push while full: `tx_ready` is low, so the byte is dropped. FIFO contents and count are unchanged.
- `tx_ready` is derived from `fifo_count` only. A pop in the same cycle does not make room for a push while full.
- Pop: FIFO not empty and FSM in IDLE, or FSM on the last cycle of STOP. The head byte loads into the shift register and the read pointer increments.
- Simultaneous push and pop: `fifo_count` is unchanged and both pointers advance.
- FSM states and transitions:
  - IDLE: `uart_t`=1. On pop, go to START.
  - START: `uart_t`=0 for `BPS_CNT` cycles, then go to DATA with bit index 0.
  - DATA: `uart_t`=shift[idx] for `BPS_CNT` cycles per bit. After idx 7 completes, go to STOP.
  - STOP: `uart_t`=1 for `BPS_CNT` cycles. On the last cycle, go to START with a pop if the FIFO is non-empty, otherwise go to IDLE.
- Back-to-back frames have no idle gap beyond the single stop bit.
- `tx_data` changes after acceptance do not affect queued or in-flight frames.
- Reset, including mid-frame: asynchronously forces `uart_t`=1, `uart_busy`=0, `tx_ready`=1, `fifo_count`=0, pointers 0, state IDLE, counters 0. The current frame and queued bytes are discarded with no truncated-frame completion.

## Timing
- Reset values: `uart_t`=1, `tx_ready`=1, `uart_busy`=0, `fifo_count`=0.
- Latency: byte pushed at edge k into an empty FIFO while IDLE.
  - Edge k: `fifo_count`=1.
  - Edge k+1: pop. `uart_t` falls, `uart_busy` rises, `fifo_count`=0.
  - `uart_t` low is visible 2 cycles after the push edge.
- Each line transition occurs exactly `BPS_CNT` cycles after the previous bit boundary. There is no drift across a frame or across back-to-back frames.
- `uart_busy` falls on the same edge that ends the last stop-bit cycle when no byte is queued.
- Capacity: `FIFO_DEPTH` bytes in the FIFO plus 1 in the shifter.
- All outputs are registered except `tx_ready`, which is a compare on registered `fifo_count`.

## Test plan
Sim parameters: `CLK_FRE`=100, `UART_BPS`=10, so `BPS_CNT`=10.
- Single byte: push 0xA5 once. `uart_t` must be 0 at 2 cycles after push, then 1,0,1,0,0,1,0,1, then 1, each level exactly 10 cycles. `uart_busy` high for 100 cycles, then returns to 0.
- Burst/full: `tx_valid` held high for 6 consecutive cycles with bytes 0x01..0x06. Exactly 0x01..0x05 are accepted and `tx_ready` goes low at the 5th accept edge. Five contiguous frames totalling 500 cycles are sent, with no high gap between a stop bit and the next start. 0x06 is never sent.
- Simultaneous push/pop: push a byte on the exact cycle STOP completes with 1 byte queued. `fifo_count` stays 1 and both bytes are later sent in order.
- Reset mid-frame: assert `sys_rst` low during data bit 3 of 0xF0 with 2 bytes queued. `uart_t`=1, `fifo_count`=0 and `tx_ready`=1 immediately. No further frames follow after release.
- Loopback: drive `uart_t` into a UART receiver block with the same parameters and send 0x00, 0xFF, 0x3C. The receiver must report exactly 0x00, 0xFF, 0x3C, one completion per byte, in order.

Source files
------------

// File: rtl/uart_send.sv
// uart_send: byte-wide transmit FIFO feeding an 8N1 serialiser on uart_t.
// Bytes enter via a tx_valid/tx_ready handshake and leave LSB first.
//
// state | meaning
// IDLE  | line high, waiting for a queued byte
// START | start bit (0) on the line
// DATA  | data bit shift_q[idx_q] on the line
// STOP  | stop bit (1); on its last cycle chain straight into the next START
module uart_send #(
  parameter int CLK_FRE    = 50000000,
  parameter int UART_BPS   = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          tx_valid,
  input  logic [7:0]                    tx_data,
  output logic                          tx_ready,
  output logic                          uart_t,
  output logic                          uart_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int          PW       = $clog2(FIFO_DEPTH);
  localparam int          BPS_CNT  = CLK_FRE / UART_BPS;
  localparam logic [15:0] BIT_LAST = 16'(BPS_CNT - 1);
  localparam logic [PW:0] DEPTH_C  = (PW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [2:0]      idx_q, idx_d;
  logic [7:0]      shift_q, shift_d;
  logic            uart_t_q, uart_t_d;
  logic            busy_q, busy_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW:0]     count_q, count_d;
  logic [7:0]      mem_q [FIFO_DEPTH];
  logic [7:0]      mem_d [FIFO_DEPTH];

  logic push, pop, not_empty, bit_done;

  // tx_ready looks only at the registered count; a same-cycle pop never frees a slot
  assign tx_ready   = (count_q < DEPTH_C);
  assign uart_t     = uart_t_q;
  assign uart_busy  = busy_q;
  assign fifo_count = count_q;

  // next-state: FIFO bookkeeping, bit timer (down-counter, advance at zero), frame sequencing
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    shift_d   = shift_q;
    uart_t_d  = uart_t_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    mem_d     = mem_q;
    pop       = 1'b0;
    push      = tx_valid && tx_ready;
    not_empty = (count_q != '0);
    bit_done  = (cnt_q == '0);

    case (state_q)
      IDLE: begin
        uart_t_d = 1'b1;
        if (not_empty) pop = 1'b1;
      end
      START: begin
        if (bit_done) begin
          state_d  = DATA;
          idx_d    = 3'd0;
          cnt_d    = BIT_LAST;
          uart_t_d = shift_q[0];
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      DATA: begin
        if (bit_done) begin
          cnt_d = BIT_LAST;
          if (idx_q == 3'd7) begin
            state_d  = STOP;
            uart_t_d = 1'b1;
          end else begin
            idx_d    = idx_q + 3'd1;
            uart_t_d = shift_q[idx_d];
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (not_empty) begin
            pop = 1'b1;
          end else begin
            state_d  = IDLE;
            uart_t_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: begin
        state_d  = IDLE;
        uart_t_d = 1'b1;
      end
    endcase

    // pop loads the shifter and starts a frame with the start bit already on the line
    if (pop) begin
      state_d  = START;
      shift_d  = mem_q[rd_ptr_q];
      rd_ptr_d = rd_ptr_q + PW'(1);
      cnt_d    = BIT_LAST;
      uart_t_d = 1'b0;
    end

    if (push) begin
      mem_d[wr_ptr_q] = tx_data;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase

    busy_d = (state_d != IDLE);
  end

  // state register; reset drops any frame in flight and empties the FIFO
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      uart_t_q <= 1'b1;
      busy_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      mem_q    <= '{default: '0};
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      uart_t_q <= uart_t_d;
      busy_q   <= busy_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: tb/tb_uart_send.sv
// Directed bench for uart_send with BPS_CNT = 10 (CLK_FRE=100, UART_BPS=10).
module tb_uart_send;

  logic       sys_clk;
  logic       sys_rst;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic       uart_t;
  logic       uart_busy;
  logic [2:0] fifo_count;

  int checks   = 0;
  int failures = 0;

  int burst_cnt [6] = '{1, 1, 2, 3, 4, 4};
  int burst_rdy [6] = '{1, 1, 1, 1, 0, 0};

  logic       rx_en = 1'b0;
  logic [7:0] rx_byte;
  logic [7:0] rx_q [$];
  int         rx_bad = 0;

  uart_send #(.CLK_FRE(100), .UART_BPS(10), .FIFO_DEPTH(4)) dut (
    .sys_clk    (sys_clk),
    .sys_rst    (sys_rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .uart_t     (uart_t),
    .uart_busy  (uart_busy),
    .fifo_count (fifo_count)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Checks line samples first..last of a frame (10 samples per bit), one per negedge.
  task automatic check_bits(input logic [7:0] b, input int first, input int last);
    logic [9:0] fr;
    fr = {1'b1, b, 1'b0};
    for (int n = first; n <= last; n++) begin
      chk($sformatf("frame_%02h_s%0d", b, n), {31'd0, uart_t}, {31'd0, fr[n / 10]});
      chk($sformatf("busy_%02h_s%0d", b, n), {31'd0, uart_busy}, 32'd1);
      @(negedge sys_clk);
    end
  endtask

  // Reference receiver: mid-bit sampling, one queue entry per good frame.
  always begin
    @(negedge sys_clk);
    if (rx_en && uart_t === 1'b0) begin
      repeat (4) @(negedge sys_clk);
      if (uart_t === 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (10) @(negedge sys_clk);
          rx_byte[i] = uart_t;
        end
        repeat (10) @(negedge sys_clk);
        if (uart_t === 1'b1) rx_q.push_back(rx_byte);
        else rx_bad++;
      end
    end
  end

  initial begin
    logic [7:0] got;
    sys_rst  = 1'b0;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    repeat (3) @(negedge sys_clk);
    chk("rst_uart_t", {31'd0, uart_t}, 32'd1);
    chk("rst_ready", {31'd0, tx_ready}, 32'd1);
    chk("rst_busy", {31'd0, uart_busy}, 32'd0);
    chk("rst_count", {29'd0, fifo_count}, 32'd0);
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);

    // single byte 0xA5
    tx_valid = 1'b1; tx_data = 8'hA5;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    chk("single_count_k", {29'd0, fifo_count}, 32'd1);
    chk("single_line_k", {31'd0, uart_t}, 32'd1);
    chk("single_busy_k", {31'd0, uart_busy}, 32'd0);
    @(negedge sys_clk);
    chk("single_count_k1", {29'd0, fifo_count}, 32'd0);
    check_bits(8'hA5, 0, 99);
    chk("single_busy_end", {31'd0, uart_busy}, 32'd0);
    chk("single_line_end", {31'd0, uart_t}, 32'd1);
    repeat (3) @(negedge sys_clk);

    // burst of six, only five fit (four queued plus one in the shifter)
    tx_valid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tx_data = 8'(i);
      @(negedge sys_clk);
      chk($sformatf("burst_count_%0d", i), {29'd0, fifo_count}, burst_cnt[i-1]);
      chk($sformatf("burst_ready_%0d", i), {31'd0, tx_ready}, burst_rdy[i-1]);
    end
    tx_valid = 1'b0;
    check_bits(8'h01, 4, 99);
    check_bits(8'h02, 0, 99);
    check_bits(8'h03, 0, 99);
    check_bits(8'h04, 0, 99);
    check_bits(8'h05, 0, 99);
    chk("burst_busy_end", {31'd0, uart_busy}, 32'd0);
    chk("burst_count_end", {29'd0, fifo_count}, 32'd0);
    for (int n = 0; n < 20; n++) begin
      chk("burst_no_06", {31'd0, uart_t}, 32'd1);
      @(negedge sys_clk);
    end

    // push on the last STOP cycle while one byte is queued
    tx_valid = 1'b1; tx_data = 8'h3A;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    @(negedge sys_clk);
    tx_valid = 1'b1; tx_data = 8'h5C;
    chk("sim_start", {31'd0, uart_t}, 32'd0);
    @(negedge sys_clk);
    tx_valid = 1'b0;
    chk("sim_count_q", {29'd0, fifo_count}, 32'd1);
    check_bits(8'h3A, 1, 98);
    tx_valid = 1'b1; tx_data = 8'hC3;
    chk("sim_stop_last", {31'd0, uart_t}, 32'd1);
    @(negedge sys_clk);
    tx_valid = 1'b0;
    chk("sim_count_same", {29'd0, fifo_count}, 32'd1);
    check_bits(8'h5C, 0, 99);
    check_bits(8'hC3, 0, 99);
    chk("sim_busy_end", {31'd0, uart_busy}, 32'd0);
    chk("sim_count_end", {29'd0, fifo_count}, 32'd0);
    repeat (3) @(negedge sys_clk);

    // reset during data bit 3 of 0xF0 with two bytes queued
    tx_valid = 1'b1; tx_data = 8'hF0;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    @(negedge sys_clk);
    tx_valid = 1'b1; tx_data = 8'h11;
    @(negedge sys_clk);
    tx_data = 8'h22;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    chk("rmid_count_q", {29'd0, fifo_count}, 32'd2);
    check_bits(8'hF0, 2, 44);
    sys_rst = 1'b0;
    #1;
    chk("rmid_line", {31'd0, uart_t}, 32'd1);
    chk("rmid_count", {29'd0, fifo_count}, 32'd0);
    chk("rmid_ready", {31'd0, tx_ready}, 32'd1);
    chk("rmid_busy", {31'd0, uart_busy}, 32'd0);
    repeat (2) @(negedge sys_clk);
    sys_rst = 1'b1;
    for (int n = 0; n < 150; n++) begin
      @(negedge sys_clk);
      chk("rmid_idle_line", {31'd0, uart_t}, 32'd1);
      chk("rmid_idle_busy", {31'd0, uart_busy}, 32'd0);
    end

    // loopback into the reference receiver
    rx_en = 1'b1;
    tx_valid = 1'b1; tx_data = 8'h00;
    @(negedge sys_clk);
    tx_data = 8'hFF;
    @(negedge sys_clk);
    tx_data = 8'h3C;
    @(negedge sys_clk);
    tx_valid = 1'b0;
    for (int n = 0; n < 400 && rx_q.size() < 3; n++) @(negedge sys_clk);
    chk("loop_rx_count", rx_q.size(), 32'd3);
    for (int i = 0; i < 3; i++) begin
      got = (rx_q.size() > i) ? rx_q[i] : 8'hxx;
      chk($sformatf("loop_rx_%0d", i), {24'd0, got}, (i == 0) ? 32'h00 : (i == 1) ? 32'hFF : 32'h3C);
    end
    chk("loop_rx_framing", rx_bad, 32'd0);
    for (int n = 0; n < 20 && uart_busy; n++) @(negedge sys_clk);
    chk("loop_busy_end", {31'd0, uart_busy}, 32'd0);
    rx_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
